note_detector: RTL

Tone receiver for the buzzer-note channel: samples a square-wave tone input (as produced by the note divider/sequencer blocks), measures its full period in clock cycles and classifies it against an 8-entry note table. It reports a stable note index, strobes on every new lock, and flags silence when edges stop. It sits on an input pin and feeds sequence-checking or display logic.

---
 rtl/note_detector.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/note_detector.sv
`default_nettype none
// ============================================================================
//  Module      : note_detector
//  Description : Buzzer-note tone receiver. Synchronizes a square-wave tone,
//                measures its rising-edge period, classifies it against an
//                8-entry note table and reports a debounced note lock, lock
//                and silence strobes.
//                Optional feature macro: NOTEDET_DUR_EN adds the 16-bit
//                note_dur output (matching-period count of the last lock).
//  Revision    : 1.0 - initial release
// ============================================================================

// Nominal DO..SI full periods in 12 MHz cycles, used when no project-wide
// note table has been defined.
`ifndef DO_10
`define DO_10 45872
`endif
`ifndef RE_10
`define RE_10 40858
`endif
`ifndef MI_10
`define MI_10 36402
`endif
`ifndef FA_10
`define FA_10 34359
`endif
`ifndef SOL_10
`define SOL_10 30612
`endif
`ifndef LA_10
`define LA_10 27273
`endif
`ifndef SI_10
`define SI_10 24297
`endif

module note_detector #(
  parameter int                CNT_W   = 24,
  parameter logic [CNT_W-1:0]  P0      = CNT_W'(`DO_10),
  parameter logic [CNT_W-1:0]  P1      = CNT_W'(`RE_10),
  parameter logic [CNT_W-1:0]  P2      = CNT_W'(`MI_10),
  parameter logic [CNT_W-1:0]  P3      = CNT_W'(`FA_10),
  parameter logic [CNT_W-1:0]  P4      = CNT_W'(`SOL_10),
  parameter logic [CNT_W-1:0]  P5      = CNT_W'(`LA_10),
  parameter logic [CNT_W-1:0]  P6      = CNT_W'(`SI_10),
  parameter logic [CNT_W-1:0]  P7      = CNT_W'(`DO_10 / 2),
  parameter int                TOL_SH  = 5,
  parameter int                STABLE  = 3,
  parameter int                SIL_CYC = 240000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tone_in,
  output logic [2:0]  note,
  output logic        valid,
  output logic        note_stb,
`ifdef NOTEDET_DUR_EN
  output logic [15:0] note_dur,
`endif
  output logic        sil_stb
);

  localparam int               MW       = (STABLE < 2) ? 1 : $clog2(STABLE + 1);
  localparam logic [MW-1:0]    c_stable = MW'(STABLE);
  localparam logic [MW-1:0]    c_mone   = MW'(1);
  localparam logic [CNT_W-1:0] c_sil    = CNT_W'(SIL_CYC);
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_tab [8] = '{P0, P1, P2, P3, P4, P5, P6, P7};

  typedef enum logic [1:0] {
    S_SILENT  = 2'd0,
    S_ARMED   = 2'd1,
    S_ACQUIRE = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  logic [1:0]       r_sync;
  logic             r_sync_d;
  logic             r_edge;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  logic [2:0]       r_cand;
  logic [MW-1:0]    r_mcnt;
  logic [2:0]       r_note;
  logic             r_valid;
  logic             r_note_stb;
  logic             r_sil_stb;

  logic [7:0]       w_match;
  logic             w_hit;
  logic [2:0]       w_idx;
  logic             w_timeout;
  logic             w_ev;
  logic             w_new;
  logic             w_same;
  logic             w_drop;
  logic [MW-1:0]    w_mnext;
  logic             w_lock;

  // Two-stage synchronizer followed by a registered rising-edge detector
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync   <= 2'b00;
      r_sync_d <= 1'b0;
      r_edge   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], tone_in};
      r_sync_d <= r_sync[1];
      r_edge   <= r_sync[1] & ~r_sync_d;
    end
  end

  // Cycles since the last detected edge; its value on an edge is the period
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (r_edge) begin
      r_cnt <= c_one;
    end else if (r_cnt < c_sil) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  // Per-entry window test; tolerance is derived from the nominal period
  for (genvar gi = 0; gi < 8; gi++) begin : g_entry
    logic [CNT_W-1:0] w_diff;
    assign w_diff       = (r_cnt >= c_tab[gi]) ? (r_cnt - c_tab[gi]) : (c_tab[gi] - r_cnt);
    assign w_match[gi]  = (w_diff <= (c_tab[gi] >> TOL_SH));
  end

  // Priority pick: the lowest matching index wins overlapping windows
  always_comb begin
    w_hit = |w_match;
    w_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_match[i]) w_idx = 3'(i);
    end
  end

  // Edge-event decode; a timeout masks any edge arriving in the same cycle
  always_comb begin
    w_timeout = (r_state != S_SILENT) && (r_cnt == c_sil);
    w_ev      = r_edge && (r_state != S_SILENT) && !w_timeout;
    w_new     = w_ev && w_hit &&
                ((r_state == S_ARMED) ||
                 ((r_state == S_ACQUIRE) && (w_idx != r_cand)) ||
                 ((r_state == S_LOCKED) && (w_idx != r_note)));
    w_same    = w_ev && w_hit && (r_state == S_ACQUIRE) && (w_idx == r_cand);
    w_drop    = w_ev && !w_hit && (r_state != S_ARMED);
    w_mnext   = w_new ? c_mone : ((r_mcnt < c_stable) ? r_mcnt + c_mone : r_mcnt);
    w_lock    = (w_new || w_same) && (w_mnext >= c_stable);
  end

  // Lock state machine with registered note/valid/strobe outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_SILENT;
      r_cand     <= 3'd0;
      r_mcnt     <= '0;
      r_note     <= 3'd0;
      r_valid    <= 1'b0;
      r_note_stb <= 1'b0;
      r_sil_stb  <= 1'b0;
    end else begin
      r_note_stb <= 1'b0;
      r_sil_stb  <= 1'b0;
      if (w_timeout) begin
        r_state   <= S_SILENT;
        r_mcnt    <= '0;
        r_valid   <= 1'b0;
        r_sil_stb <= 1'b1;
      end else if (r_edge && (r_state == S_SILENT)) begin
        // First edge only starts the period count
        r_state <= S_ARMED;
      end else if (w_lock) begin
        r_state    <= S_LOCKED;
        r_cand     <= w_idx;
        r_mcnt     <= w_mnext;
        r_note     <= w_idx;
        r_valid    <= 1'b1;
        r_note_stb <= 1'b1;
      end else if (w_new || w_same) begin
        r_state <= S_ACQUIRE;
        r_cand  <= w_idx;
        r_mcnt  <= w_mnext;
        r_valid <= 1'b0;
      end else if (w_drop) begin
        r_state <= S_ARMED;
        r_mcnt  <= '0;
        r_valid <= 1'b0;
      end
    end
  end

`ifdef NOTEDET_DUR_EN
  logic        w_stay;
  logic [15:0] r_dur_cnt;
  logic [15:0] r_note_dur;

  assign w_stay = w_ev && w_hit && (r_state == S_LOCKED) && (w_idx == r_note);

  // Matching-period count of the current candidate, captured when a lock ends
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dur_cnt  <= 16'd0;
      r_note_dur <= 16'd0;
    end else begin
      if (w_new) begin
        r_dur_cnt <= 16'd1;
      end else if ((w_same || w_stay) && (r_dur_cnt != 16'hFFFF)) begin
        r_dur_cnt <= r_dur_cnt + 16'd1;
      end
      if ((r_state == S_LOCKED) && (w_timeout || w_new || w_drop)) begin
        r_note_dur <= r_dur_cnt;
      end
    end
  end

  assign note_dur = r_note_dur;
`endif

  assign note     = r_note;
  assign valid    = r_valid;
  assign note_stb = r_note_stb;
  assign sil_stb  = r_sil_stb;

endmodule

`default_nettype wire
